// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the fetch stage.
// Holds the loader state encoding, the word geometry and the byte-packing helper.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSN_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    // Shift one stream byte into a partially assembled instruction word.
    function automatic logic [INSN_W-1:0] pack_byte(
        input logic [INSN_W-1:0] word,
        input logic [7:0]        data_byte,
        input logic              big_endian
    );
        if (big_endian) begin
            return {word[INSN_W-9:0], data_byte};
        end
        return {data_byte, word[INSN_W-1:8]};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Byte-to-word packer: 2-bit lane counter plus shift register.
// word_full flags the cycle in which the 4th byte of a word is being accepted.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        data_byte,
    output logic [INSN_W-1:0] word,
    output logic              word_full
);

    logic [1:0] cnt;

    assign word_full = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (clear) begin
            cnt  <= 2'd0;
        end else if (byte_valid) begin
            cnt  <= cnt + 2'd1;
            word <= pack_byte(word, data_byte, BIG_ENDIAN);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the CPU in reset until done.
// Optional LOADER_CHECKSUM_EN: a trailing XOR-of-data byte must match before DONE.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INSN_W-1:0] imem_wdata,
    output logic              cpu_rst_hold,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_nx;
    logic [15:0]       len;
    logic [15:0]       len_rx;
    logic [ADDR_W:0]   idx;
    logic [INSN_W-1:0] word;
    logic              accept;
    logic              byte_valid;
    logic              word_full;
    logic              start_load;
    logic              last_word;
    logic              len_zero;
    logic              len_big;
    logic              done_q;
    logic              err_q;
    logic              hold_q;

    assign rx_ready   = (state == LEN_HI) || (state == LEN_LO) ||
                        (state == DATA)   || (state == CSUM);
    assign accept     = rx_valid && rx_ready;
    assign byte_valid = accept && (state == DATA);
    assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERROR));

    // Length decision is made on the LEN_LO byte itself, before it is registered.
    assign len_rx    = {len[15:8], rx_data};
    assign len_zero  = (len_rx == 16'd0);
    assign len_big   = (32'(len_rx) > (32'd1 << ADDR_W));
    assign last_word = (32'(idx) == (32'(len) - 32'd1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (start_load) begin
            csum <= 8'd0;
        end else if (byte_valid) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    imem_word_packer #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_load),
        .byte_valid(byte_valid),
        .data_byte (rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_nx = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_zero) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nx = CSUM;
`else
                        state_nx = DONE;
`endif
                    end else if (len_big) begin
                        state_nx = ERROR;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (word_full) state_nx = WRITE;
            end
            WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nx = CSUM;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) state_nx = (rx_data == csum) ? DONE : ERROR;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len <= 16'd0;
            idx <= '0;
        end else begin
            if (start_load) begin
                idx <= '0;
            end else if (state == WRITE) begin
                idx <= idx + 1'b1;
            end
            if (accept && (state == LEN_HI)) len[15:8] <= rx_data;
            if (accept && (state == LEN_LO)) len[7:0]  <= rx_data;
        end
    end

    // Status flags follow the next state so they change on the cycle DONE/ERROR is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            hold_q <= 1'b1;
        end else begin
            done_q <= (state_nx == DONE);
            err_q  <= (state_nx == ERROR);
            hold_q <= (state_nx != DONE);
        end
    end

    assign imem_we      = (state == WRITE);
    assign imem_addr    = idx[ADDR_W-1:0];
    assign imem_wdata   = word;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_rst_hold = hold_q;

endmodule
